i2c_target_receiver: RTL and testbench

//  I2C target-side write receiver: the far end of the bus from the byte transmitter controller.

---
 rtl/i2c_target_receiver.sv | 176 +++++++++++++++++
 tb/tb_i2c_target_receiver.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_target_receiver.sv
// I2C target-side write receiver.
// Oversamples SCL/SDA, detects START/STOP, and shifts in the address byte and
// the data bytes. ACK/NACK is driven on SDA through an open-drain enable.
// Data bytes that were ACKed are handed to local logic over valid/ready.
//
// state     | meaning
// ----------+------------------------------------------------------------
// IDLE      | bus free, waiting for START
// ADDR      | shifting in {addr[6:0], rw}
// ADDR_ACK  | driving ACK for our address through the 9th SCL pulse
// DATA      | shifting in a data byte
// DATA_ACK  | driving ACK for an accepted data byte through the 9th pulse
// DATA_NACK | byte dropped (consumer full); SDA released through 9th pulse
// IGNORE    | foreign address or read request; wait for START/STOP
module i2c_target_receiver #(
  parameter logic [6:0] DEV_ADDR = 7'h42
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_oe,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       rx_first,
  output logic       start_det,
  output logic       stop_det,
  output logic       overflow,
  output logic       busy,
  output logic [7:0] byte_count
);

  typedef enum logic [2:0] {
    IDLE, ADDR, ADDR_ACK, DATA, DATA_ACK, DATA_NACK, IGNORE
  } state_t;

  state_t      state, state_n;
  logic [2:0]  scl_sync, sda_sync;
  logic [3:0]  bit_cnt, bit_cnt_n;
  logic [7:0]  shift, shift_n;
  logic [7:0]  byte_count_n, rx_data_n;
  logic        rx_valid_n, rx_first_n, sda_oe_n;
  logic        start_det_n, stop_det_n, overflow_n;
  logic        scl_rise, scl_fall, sda_rise, sda_fall, scl_high, sda_bit;
  logic        start_cond, stop_cond;

  // Synchronize the pads; the third stage gives the previous value for edges.
  always_ff @(posedge clk) begin
    if (reset) begin
      scl_sync <= 3'b111;
      sda_sync <= 3'b111;
    end else begin
      scl_sync <= {scl_sync[1:0], scl_in};
      sda_sync <= {sda_sync[1:0], sda_in};
    end
  end

  assign scl_high   = scl_sync[1];
  assign sda_bit    = sda_sync[1];
  assign scl_rise   = scl_sync[1] & ~scl_sync[2];
  assign scl_fall   = ~scl_sync[1] & scl_sync[2];
  assign sda_rise   = sda_sync[1] & ~sda_sync[2];
  assign sda_fall   = ~sda_sync[1] & sda_sync[2];
  assign start_cond = sda_fall & scl_high;
  assign stop_cond  = sda_rise & scl_high;
  assign busy       = (state != IDLE);

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      bit_cnt    <= 4'd0;
      shift      <= 8'h00;
      byte_count <= 8'h00;
      rx_data    <= 8'h00;
      rx_valid   <= 1'b0;
      rx_first   <= 1'b0;
      sda_oe     <= 1'b0;
      start_det  <= 1'b0;
      stop_det   <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      state      <= state_n;
      bit_cnt    <= bit_cnt_n;
      shift      <= shift_n;
      byte_count <= byte_count_n;
      rx_data    <= rx_data_n;
      rx_valid   <= rx_valid_n;
      rx_first   <= rx_first_n;
      sda_oe     <= sda_oe_n;
      start_det  <= start_det_n;
      stop_det   <= stop_det_n;
      overflow   <= overflow_n;
    end
  end

  // Next-state logic. bit_cnt counts samples 0..8 in ADDR/DATA; in the ACK
  // states it only records that the 9th rising edge has been seen.
  always_comb begin
    state_n      = state;
    bit_cnt_n    = bit_cnt;
    shift_n      = shift;
    byte_count_n = byte_count;
    rx_data_n    = rx_data;
    rx_valid_n   = rx_valid & ~rx_ready;
    rx_first_n   = rx_first;
    sda_oe_n     = sda_oe;
    start_det_n  = 1'b0;
    stop_det_n   = 1'b0;
    overflow_n   = 1'b0;

    if (start_cond) begin
      state_n      = ADDR;
      bit_cnt_n    = 4'd0;
      byte_count_n = 8'h00;
      sda_oe_n     = 1'b0;
      start_det_n  = 1'b1;
    end else if (stop_cond) begin
      state_n    = IDLE;
      bit_cnt_n  = 4'd0;
      sda_oe_n   = 1'b0;
      stop_det_n = 1'b1;
    end else begin
      case (state)
        ADDR: begin
          if (scl_rise && bit_cnt != 4'd8) begin
            shift_n   = {shift[6:0], sda_bit};
            bit_cnt_n = bit_cnt + 4'd1;
          end else if (scl_fall && bit_cnt == 4'd8) begin
            bit_cnt_n = 4'd0;
            if (shift == {DEV_ADDR, 1'b0}) begin
              sda_oe_n = 1'b1;
              state_n  = ADDR_ACK;
            end else begin
              sda_oe_n = 1'b0;
              state_n  = IGNORE;
            end
          end
        end
        DATA: begin
          if (scl_rise && bit_cnt != 4'd8) begin
            shift_n   = {shift[6:0], sda_bit};
            bit_cnt_n = bit_cnt + 4'd1;
          end else if (scl_fall && bit_cnt == 4'd8) begin
            bit_cnt_n = 4'd0;
            if (!rx_valid || rx_ready) begin
              rx_data_n    = shift;
              rx_valid_n   = 1'b1;
              rx_first_n   = (byte_count == 8'h00);
              byte_count_n = (byte_count == 8'hFF) ? 8'hFF : byte_count + 8'd1;
              sda_oe_n     = 1'b1;
              state_n      = DATA_ACK;
            end else begin
              overflow_n = 1'b1;
              sda_oe_n   = 1'b0;
              state_n    = DATA_NACK;
            end
          end
        end
        ADDR_ACK, DATA_ACK, DATA_NACK: begin
          if (scl_rise) begin
            bit_cnt_n = 4'd1;
          end else if (scl_fall && bit_cnt != 4'd0) begin
            bit_cnt_n = 4'd0;
            sda_oe_n  = 1'b0;
            state_n   = DATA;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_target_receiver.sv
// Bench for i2c_target_receiver: a bit-banged bus master, a byte-level
// reference model of the target, and a scoreboard monitor on the rx port.
module tb_i2c_target_receiver;
  localparam int H = 10;  // SCL half period in clk cycles

  logic       clk = 1'b0;
  logic       reset;
  logic       scl_in, m_sda, sda_in;
  logic       sda_oe, rx_valid, rx_ready, rx_first;
  logic       start_det, stop_det, overflow, busy;
  logic [7:0] rx_data, byte_count;

  always #5 clk = ~clk;
  assign sda_in = m_sda & ~sda_oe;

  i2c_target_receiver #(.DEV_ADDR(7'h42)) dut (
    .clk(clk), .reset(reset), .scl_in(scl_in), .sda_in(sda_in),
    .sda_oe(sda_oe), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .rx_first(rx_first), .start_det(start_det),
    .stop_det(stop_det), .overflow(overflow), .busy(busy),
    .byte_count(byte_count)
  );

  typedef struct { logic [7:0] d; logic f; } exp_t;
  exp_t exp_q[$];

  int compared = 0, mismatched = 0;
  int m_bc = 0;
  bit m_held = 0, m_addressed = 0;
  int exp_ovf = 0, exp_start = 0, exp_stop = 0;
  int ovf_cnt = 0, start_cnt = 0, stop_cnt = 0;

  task automatic check(input string name, input int act, input int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic wclk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Scoreboard monitor: pops on every handshake, counts event pulses,
  // and watches that SDA drive never moves while SCL is high.
  initial begin : monitor
    exp_t e;
    logic prev_oe, prev_rst;
    prev_oe = 1'b0;
    prev_rst = 1'b1;
    forever begin
      @(negedge clk);
      #1;
      if (!reset) begin
        if (start_det) start_cnt++;
        if (stop_det)  stop_cnt++;
        if (overflow)  ovf_cnt++;
        if (rx_valid && rx_ready) begin
          if (exp_q.size() == 0) begin
            compared++;
            mismatched++;
            $display("FAIL rx_unexpected: got byte %0h expected none", rx_data);
          end else begin
            e = exp_q.pop_front();
            check("rx_data", rx_data, e.d);
            check("rx_first", rx_first, e.f);
          end
        end
        if (sda_oe !== prev_oe && scl_in && !prev_rst) begin
          compared++;
          mismatched++;
          $display("FAIL sda_oe_while_scl_high: got %0b expected %0b", sda_oe, prev_oe);
        end
      end
      prev_oe = sda_oe;
      prev_rst = reset;
    end
  end

  task automatic bus_start();
    m_sda = 1'b1; wclk(H/2);
    scl_in = 1'b1; wclk(H/2);
    m_sda = 1'b0; wclk(H/2);
    scl_in = 1'b0;
    exp_start++;
    m_bc = 0;
    m_addressed = 0;
  endtask

  task automatic bus_stop();
    m_sda = 1'b0; wclk(H/2);
    scl_in = 1'b1; wclk(H/2);
    m_sda = 1'b1; wclk(H);
    exp_stop++;
    m_addressed = 0;
  endtask

  task automatic send_bits(input logic [7:0] b, input int n);
    for (int i = 0; i < n; i++) begin
      wclk(H/2); m_sda = b[7-i];
      wclk(H/2); scl_in = 1'b1;
      wclk(H);   scl_in = 1'b0;
    end
  endtask

  task automatic ack_slot(input bit exp_ack, input string name);
    wclk(H/2); m_sda = 1'b1;
    wclk(H/2); scl_in = 1'b1;
    wclk(H/2);
    check(name, !sda_in, exp_ack);
    wclk(H/2); scl_in = 1'b0;
  endtask

  task automatic addr_byte(input logic [7:0] a);
    bit match;
    match = (a[7:1] == 7'h42) && (a[0] == 1'b0);
    send_bits(a, 8);
    ack_slot(match, "addr_ack");
    m_addressed = match;
  endtask

  task automatic data_byte(input logic [7:0] d);
    exp_t e;
    bit ack;
    ack = 0;
    if (m_addressed) begin
      if (m_held) begin
        exp_ovf++;
      end else begin
        ack = 1;
        e.d = d;
        e.f = (m_bc == 0);
        exp_q.push_back(e);
        m_bc = (m_bc < 255) ? m_bc + 1 : 255;
        if (!rx_ready) m_held = 1;
      end
    end
    send_bits(d, 8);
    ack_slot(ack, "data_ack");
  endtask

  task automatic end_xfer();
    bus_stop();
    check("busy_after_stop", busy, 0);
    check("sda_oe_after_stop", sda_oe, 0);
    check("byte_count", byte_count, m_bc);
  endtask

  task automatic release_ready();
    rx_ready = 1'b1;
    wclk(4);
    m_held = 0;
  endtask

  task automatic check_counts();
    check("start_pulses", start_cnt, exp_start);
    check("stop_pulses", stop_cnt, exp_stop);
    check("overflow_pulses", ovf_cnt, exp_ovf);
    check("scoreboard_drained", exp_q.size(), 0);
  endtask

  initial begin
    int nb, sel;
    logic [7:0] a;
    reset = 1'b1; scl_in = 1'b1; m_sda = 1'b1; rx_ready = 1'b1;
    wclk(3);
    check("reset_sda_oe", sda_oe, 0);
    check("reset_busy", busy, 0);
    check("reset_rx_valid", rx_valid, 0);
    check("reset_rx_data", rx_data, 0);
    check("reset_byte_count", byte_count, 0);
    reset = 1'b0;
    wclk(4);

    // 1: basic write
    bus_start(); addr_byte(8'h84); data_byte(8'hA5); end_xfer();
    check_counts();

    // 2: foreign address, then read request
    bus_start(); addr_byte(8'h86); data_byte(8'h12); data_byte(8'h34);
    check("nack_no_valid", rx_valid, 0);
    end_xfer();
    bus_start(); addr_byte(8'h85); data_byte(8'h56); data_byte(8'h78);
    check("read_no_valid", rx_valid, 0);
    end_xfer();
    check_counts();

    // 3: consumer stalled
    rx_ready = 1'b0;
    bus_start(); addr_byte(8'h84); data_byte(8'h11); data_byte(8'h22);
    end_xfer();
    check("held_valid", rx_valid, 1);
    check("held_data", rx_data, 8'h11);
    release_ready();
    check_counts();

    // 4: repeated START mid-byte
    bus_start(); addr_byte(8'h84); send_bits(8'hF0, 4);
    bus_start(); addr_byte(8'h84); data_byte(8'h3C); end_xfer();
    check_counts();

    // 5: STOP mid-byte with consumer stalled
    rx_ready = 1'b0;
    bus_start(); addr_byte(8'h84); send_bits(8'h9B, 5); bus_stop();
    check("partial_busy", busy, 0);
    check("partial_no_valid", rx_valid, 0);
    check("partial_sda_oe", sda_oe, 0);
    rx_ready = 1'b1;
    check_counts();

    // 6: reset while driving the data ACK
    bus_start(); addr_byte(8'h84); data_byte_noack(8'hA5);
    reset = 1'b1;
    wclk(1);
    check("rst_sda_oe", sda_oe, 0);
    check("rst_busy", busy, 0);
    check("rst_rx_valid", rx_valid, 0);
    check("rst_rx_data", rx_data, 0);
    check("rst_byte_count", byte_count, 0);
    wclk(1);
    reset = 1'b0;
    m_bc = 0; m_held = 0; m_addressed = 0;
    wclk(4);
    bus_start(); addr_byte(8'h84); data_byte(8'hC3); data_byte(8'h5A); end_xfer();
    check_counts();

    // randomized transfers against the model
    for (int it = 0; it < 20; it++) begin
      rx_ready = ($urandom_range(0, 2) != 0);
      sel = $urandom_range(0, 9);
      a = (sel < 7) ? 8'h84 : ((sel < 9) ? 8'h86 : 8'h85);
      bus_start();
      addr_byte(a);
      nb = $urandom_range(1, 4);
      for (int k = 0; k < nb; k++) data_byte(8'($urandom));
      if ($urandom_range(0, 3) == 0) send_bits(8'($urandom), $urandom_range(1, 7));
      end_xfer();
      release_ready();
    end
    check_counts();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  // Sends 8 data bits (model expects ACK) and stops with SCL high during the
  // 9th pulse while the target is driving ACK.
  task automatic data_byte_noack(input logic [7:0] d);
    exp_t e;
    e.d = d;
    e.f = (m_bc == 0);
    exp_q.push_back(e);
    send_bits(d, 8);
    wclk(H/2); m_sda = 1'b1;
    wclk(H/2); scl_in = 1'b1;
    wclk(2);
    check("ack_before_reset", sda_oe, 1);
  endtask

endmodule
